mips_multicycle_cpu: RTL and testbench

//  Multi-cycle MIPS core; successor to the single-cycle cpu. Parametrised address width and reset vector.

---
 rtl/mips_multicycle_cpu_pkg.sv | 99 +++++++++
 rtl/mips_multicycle_cpu_fsm.sv | 115 +++++++++++
 rtl/mips_multicycle_cpu.sv | 134 +++++++++++++
 tb/tb_mips_multicycle_cpu.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_multicycle_cpu_pkg.sv
// Shared definitions for the multi-cycle MIPS core: FSM state encodings,
// opcode/funct constants, ALU operand-source codes, the per-instruction
// control word with its decoder, and the ALU itself.
package mips_multicycle_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_e;

  // Second ALU operand: register B, sign-extended immediate, or zero-extended shamt.
  typedef enum logic [1:0] {
    B_SRC_REG, B_SRC_SEXT, B_SRC_SHAMT
  } b_src_e;

  // Instruction class steers the FSM after EXEC.
  typedef enum logic [2:0] {
    CL_ALU, CL_LW, CL_SW, CL_BEQ, CL_J, CL_NOP
  } iclass_e;

  typedef struct packed {
    iclass_e cls;
    alu_op_e alu_op;
    b_src_e  b_src;
    logic    a_is_rt;  // shifts operate on rt, not rs
    logic    dst_rd;   // R-type writes rd, I-type writes rt
  } ctrl_t;

  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '{cls: CL_NOP, alu_op: ALU_ADD, b_src: B_SRC_REG, a_is_rt: 1'b0, dst_rd: 1'b0};
    case (op)
      OP_RTYPE: begin
        c.cls    = CL_ALU;
        c.dst_rd = 1'b1;
        case (fn)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          FN_SLL:  begin c.alu_op = ALU_SLL; c.b_src = B_SRC_SHAMT; c.a_is_rt = 1'b1; end
          FN_SRL:  begin c.alu_op = ALU_SRL; c.b_src = B_SRC_SHAMT; c.a_is_rt = 1'b1; end
          default: c.cls = CL_NOP;
        endcase
      end
      OP_ADDI: begin c.cls = CL_ALU; c.alu_op = ALU_ADD; c.b_src = B_SRC_SEXT; end
      OP_SLTI: begin c.cls = CL_ALU; c.alu_op = ALU_SLT; c.b_src = B_SRC_SEXT; end
      OP_ANDI: begin c.cls = CL_ALU; c.alu_op = ALU_AND; c.b_src = B_SRC_SEXT; end
      OP_ORI:  begin c.cls = CL_ALU; c.alu_op = ALU_OR;  c.b_src = B_SRC_SEXT; end
      OP_LW:   begin c.cls = CL_LW;  c.alu_op = ALU_ADD; c.b_src = B_SRC_SEXT; end
      OP_SW:   begin c.cls = CL_SW;  c.alu_op = ALU_ADD; c.b_src = B_SRC_SEXT; end
      OP_BEQ:  begin c.cls = CL_BEQ; c.alu_op = ALU_SUB; end
      OP_J:    c.cls = CL_J;
      default: c.cls = CL_NOP;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_cpu_fsm.sv
// Control FSM of the multi-cycle core: state register plus next-state and
// one-cycle enable decode for every datapath register.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cls_i           class of the instruction held in the IR
//   mem_ready_i     memory handshake completion
//   state_o         current state (debug / bus address select)
//   mem_req_o       bus request (FETCH/MEM only, forced low in reset)
//   mem_we_o        bus write (MEM of a store)
//   ir_we_o .. mdr_we_o, rf_we_o, pc_we_o, retire_o   datapath enables
module mips_multicycle_cpu_fsm
  import mips_multicycle_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cls_i,
  input  logic       mem_ready_i,
  output logic [2:0] state_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       ir_we_o,
  output logic       ab_we_o,
  output logic       alu_we_o,
  output logic       mdr_we_o,
  output logic       rf_we_o,
  output logic       pc_we_o,
  output logic       retire_o
);

  state_e  state_q, state_d;
  iclass_e cls;

  assign cls     = iclass_e'(cls_i);
  assign state_o = state_q;

  // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    ir_we_o   = 1'b0;
    ab_we_o   = 1'b0;
    alu_we_o  = 1'b0;
    mdr_we_o  = 1'b0;
    rf_we_o   = 1'b0;
    pc_we_o   = 1'b0;
    retire_o  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_we_o = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ab_we_o = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        alu_we_o = 1'b1;
        case (cls)
          CL_LW, CL_SW: state_d = ST_MEM;
          CL_ALU:       state_d = ST_WB;
          default: begin  // beq, j and unrecognised opcodes finish here
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        mem_req_o = 1'b1;
        mem_we_o  = (cls == CL_SW);
        if (mem_ready_i) begin
          if (cls == CL_SW) begin
            pc_we_o  = 1'b1;
            retire_o = 1'b1;
            state_d  = ST_FETCH;
          end else begin
            mdr_we_o = 1'b1;
            state_d  = ST_WB;
          end
        end
      end
      ST_WB: begin
        rf_we_o  = 1'b1;
        pc_we_o  = 1'b1;
        retire_o = 1'b1;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    // Reset suppresses the bus and every state update of an aborted instruction.
    if (rst) begin
      state_d   = ST_FETCH;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      ir_we_o   = 1'b0;
      ab_we_o   = 1'b0;
      alu_we_o  = 1'b0;
      mdr_we_o  = 1'b0;
      rf_we_o   = 1'b0;
      pc_we_o   = 1'b0;
      retire_o  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/mips_multicycle_cpu.sv
// Multi-cycle MIPS core with a single shared instruction/data bus using a
// req/ready handshake. Holds the datapath registers (pc, ir, A, B, ALUOut,
// MDR, register file, retired counter); sequencing lives in the FSM.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   mem_req/we/addr/wdata  bus request, write flag, byte address, store data
//   mem_rdata, mem_ready   bus read data, transfer completion
//   pc_out                 address of the instruction in flight
//   state_out              FSM state (debug)
//   retired                completed-instruction count (wraps)
module mips_multicycle_cpu
  import mips_multicycle_cpu_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [2:0]            state_out,
  output logic [CNT_WIDTH-1:0]  retired
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [31:0]           ir_q, a_q, b_q, alu_out_q, mdr_q;
  logic [CNT_WIDTH-1:0]  retired_q;
  logic [31:0]           rf [32];

  logic [2:0] state;
  logic       ir_we, ab_we, alu_we, mdr_we, rf_we, pc_we, retire;

  ctrl_t                 ctrl;
  logic [4:0]            rs, rt, rd, wr_addr;
  logic [31:0]           imm_sext, alu_a, alu_b, alu_res, rf_a, rf_b, wr_data;
  logic [ADDR_WIDTH-1:0] pc_plus4, pc_next;
  logic                  unused_bits;

  assign ctrl     = decode(ir_q[31:26], ir_q[5:0]);
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  mips_multicycle_cpu_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .cls_i       (ctrl.cls),
    .mem_ready_i (mem_ready),
    .state_o     (state),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .ir_we_o     (ir_we),
    .ab_we_o     (ab_we),
    .alu_we_o    (alu_we),
    .mdr_we_o    (mdr_we),
    .rf_we_o     (rf_we),
    .pc_we_o     (pc_we),
    .retire_o    (retire)
  );

  // Register file: $0 is hard-wired to zero on the read side.
  assign rf_a = (rs == 5'd0) ? 32'h0 : rf[rs];
  assign rf_b = (rt == 5'd0) ? 32'h0 : rf[rt];

  always_comb begin
    alu_a = ctrl.a_is_rt ? b_q : a_q;
    case (ctrl.b_src)
      B_SRC_SEXT:  alu_b = imm_sext;
      B_SRC_SHAMT: alu_b = {27'b0, ir_q[10:6]};
      default:     alu_b = b_q;
    endcase
  end

  assign alu_res = alu(ctrl.alu_op, alu_a, alu_b);

  // pc arithmetic wraps modulo 2^ADDR_WIDTH. Only EXEC of beq/j departs from
  // pc+4; in MEM/WB the class is lw/sw/alu, so the class alone picks the target.
  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  always_comb begin
    case (ctrl.cls)
      CL_BEQ:  pc_next = (alu_res == 32'h0)
                         ? pc_plus4 + {imm_sext[ADDR_WIDTH-3:0], 2'b00}
                         : pc_plus4;
      CL_J:    pc_next = {ir_q[ADDR_WIDTH-3:0], 2'b00};
      default: pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
    end else begin
      if (ir_we)  ir_q      <= mem_rdata;
      if (ab_we)  begin a_q <= rf_a; b_q <= rf_b; end
      if (alu_we) alu_out_q <= alu_res;
      if (mdr_we) mdr_q     <= mem_rdata;
      if (pc_we)  pc_q      <= pc_next;
      if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
    end
  end

  assign wr_addr = ctrl.dst_rd ? rd : rt;
  assign wr_data = (ctrl.cls == CL_LW) ? mdr_q : alu_out_q;

  // NOTE: the register file is a storage array and is deliberately not reset; software initialises what it reads.
  always_ff @(posedge clk) begin
    if (rf_we && (wr_addr != 5'd0)) rf[wr_addr] <= wr_data;
  end

  // In MEM the bus carries the computed data address, otherwise the pc.
  assign mem_addr  = (state == ST_MEM) ? alu_out_q[ADDR_WIDTH-1:0] : pc_q;
  assign mem_wdata = b_q;

  assign pc_out    = pc_q;
  assign state_out = state;
  assign retired   = retired_q;

  assign unused_bits = ^alu_out_q[31:ADDR_WIDTH];

endmodule

// File: tb/tb_mips_multicycle_cpu.sv
// Self-checking bench for mips_multicycle_cpu with a wait-state memory model
// and two scoreboards: expected retirements and expected memory writes.
module tb_mips_multicycle_cpu;

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_MEM   = 3'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req, mem_we, mem_ready;
  logic [7:0]  mem_addr, pc_out;
  logic [31:0] mem_wdata, mem_rdata, retired;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  mips_multicycle_cpu #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .CNT_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .state_out (state_out),
    .retired   (retired)
  );

  // Memory model: 64 words, programmable wait states per transfer.
  logic [31:0] mem  [64];
  logic [31:0] prog [64];
  logic        load_en = 1'b0;
  int          wait_cycles = 0;
  int          wait_cnt = 0;

  assign mem_ready = (wait_cnt >= wait_cycles);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (load_en) mem <= prog;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    if (rst)          wait_cnt <= 0;
    else if (mem_req) wait_cnt <= mem_ready ? 0 : wait_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {int lat; logic [7:0] pc; int cnt;} ret_t;
  typedef struct {logic [7:0] addr; logic [31:0] data;} wr_t;
  ret_t ret_q[$];
  wr_t  wr_q[$];
  int   exp_cnt;

  task automatic push_ret(input int lat, input logic [7:0] pc);
    exp_cnt++;
    ret_q.push_back('{lat, pc, exp_cnt});
  endtask

  task automatic push_wr(input logic [7:0] addr, input logic [31:0] data);
    wr_q.push_back('{addr, data});
  endtask

  function automatic logic [31:0] enc_r(input int rs, rt, rd, sh, fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, rs, rt, imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int target);
    return {6'h02, 26'(target)};
  endfunction

  // Monitor: everything sampled on the falling edge.
  logic [31:0] last_retired;
  int          cyc_since;
  logic [7:0]  cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;
  ret_t        re;
  wr_t         we;

  always @(negedge clk) begin
    if (rst) begin
      last_retired = 0;
      cyc_since    = 0;
    end else begin
      if (retired !== last_retired) begin
        if (ret_q.size() > 0) begin
          re = ret_q.pop_front();
          check("retire_latency", cyc_since, re.lat);
          check("pc_after_retire", {24'h0, pc_out}, {24'h0, re.pc});
          check("retired_count", retired, re.cnt);
        end
        last_retired = retired;
        cyc_since    = 0;
      end
      cyc_since++;
      if (mem_req && wait_cnt == 0) begin
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
      end else if (mem_req && wait_cycles > 0) begin
        check("stable_addr", {24'h0, mem_addr}, {24'h0, cap_addr});
        check("stable_we", {31'h0, mem_we}, {31'h0, cap_we});
        check("stable_wdata", mem_wdata, cap_wdata);
      end
      if (mem_req && mem_ready && mem_we) begin
        if (wr_q.size() == 0) begin
          check("write_expected", wr_q.size(), 1);
        end else begin
          we = wr_q.pop_front();
          check("write_addr", {24'h0, mem_addr}, {24'h0, we.addr});
          check("write_data", mem_wdata, we.data);
        end
      end
    end
  end

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    exp_cnt = 0;
  endtask

  task automatic load_and_start(input int waits);
    rst         = 1'b1;
    wait_cycles = waits;
    load_en     = 1'b1;
    @(posedge clk); #1 load_en = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic run_prog(input int budget);
    int n = 0;
    while ((ret_q.size() > 0 || wr_q.size() > 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("run_ret_pending", ret_q.size(), 0);
    check("run_wr_pending", wr_q.size(), 0);
    @(posedge clk); #1 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset held with a ready memory; ALU ops, stores and $0 write discard.
    clear_prog();
    prog[0]  = enc_i(8'h08, 0, 1, -3);         // addi $1,$0,-3
    prog[1]  = enc_r(1, 1, 2, 0, 8'h20);       // add  $2,$1,$1
    prog[2]  = enc_i(8'h2B, 0, 1, 8'h80);      // sw   $1,0x80($0)
    prog[3]  = enc_i(8'h2B, 0, 2, 8'h84);      // sw   $2,0x84($0)
    prog[4]  = enc_r(0, 1, 3, 4, 8'h00);       // sll  $3,$1,4
    prog[5]  = enc_r(0, 1, 4, 28, 8'h02);      // srl  $4,$1,28
    prog[6]  = enc_r(1, 0, 5, 0, 8'h2A);       // slt  $5,$1,$0
    prog[7]  = enc_i(8'h0C, 1, 6, -16);        // andi $6,$1,-16
    prog[8]  = enc_r(0, 1, 7, 0, 8'h22);       // sub  $7,$0,$1
    prog[9]  = enc_r(3, 4, 8, 0, 8'h25);       // or   $8,$3,$4
    prog[10] = enc_i(8'h0A, 1, 9, -2);         // slti $9,$1,-2
    prog[11] = enc_i(8'h08, 0, 0, 5);          // addi $0,$0,5
    for (int r = 3; r <= 9; r++) prog[9 + r] = enc_i(8'h2B, 0, r, 8'h88 + 4 * (r - 3));
    prog[19] = enc_i(8'h2B, 0, 0, 8'hA4);      // sw   $0,0xA4($0)
    prog[20] = enc_j(20);                      // j    self
    for (int i = 0; i < 20; i++) push_ret(4, 8'(4 * (i + 1)));
    push_ret(3, 8'd80);
    push_wr(8'h80, 32'hFFFF_FFFD);
    push_wr(8'h84, 32'hFFFF_FFFA);
    push_wr(8'h88, 32'hFFFF_FFD0);
    push_wr(8'h8C, 32'h0000_000F);
    push_wr(8'h90, 32'h0000_0001);
    push_wr(8'h94, 32'hFFFF_FFF0);
    push_wr(8'h98, 32'h0000_0003);
    push_wr(8'h9C, 32'hFFFF_FFDF);
    push_wr(8'hA0, 32'h0000_0001);
    push_wr(8'hA4, 32'h0000_0000);
    wait_cycles = 0;
    load_en = 1'b1;
    @(posedge clk); #1 load_en = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_mem_req", {31'h0, mem_req}, 32'h0);
      check("rst_mem_we", {31'h0, mem_we}, 32'h0);
      check("rst_state", {29'h0, state_out}, {29'h0, S_FETCH});
      check("rst_retired", retired, 32'h0);
      @(posedge clk);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    check("first_req", {31'h0, mem_req}, 32'h1);
    check("first_addr", {24'h0, mem_addr}, 32'h0);
    check("first_retired", retired, 32'h0);
    run_prog(500);

    // Store into the instruction stream, then load it back.
    clear_prog();
    prog[0] = enc_i(8'h08, 0, 1, 8);           // addi $1,$0,8
    prog[1] = enc_i(8'h08, 0, 2, -6);          // addi $2,$0,-6
    prog[2] = enc_i(8'h2B, 1, 2, 4);           // sw   $2,4($1)  -> addr 12
    prog[4] = enc_i(8'h23, 1, 3, 4);           // lw   $3,4($1)
    prog[5] = enc_i(8'h2B, 0, 3, 8'h40);       // sw   $3,0x40($0)
    prog[6] = enc_j(6);
    push_ret(4, 8'd4);
    push_ret(4, 8'd8);
    push_ret(4, 8'd12);
    push_ret(3, 8'd16);                        // overwritten word decodes as an unknown opcode
    push_ret(5, 8'd20);
    push_ret(4, 8'd24);
    push_ret(3, 8'd24);
    push_wr(8'd12, 32'hFFFF_FFFA);
    push_wr(8'h40, 32'hFFFF_FFFA);
    load_and_start(0);
    run_prog(500);

    // Three wait states on every transfer.
    clear_prog();
    prog[0] = enc_i(8'h08, 0, 1, 8'h55);       // addi $1,$0,0x55
    prog[1] = enc_i(8'h2B, 0, 1, 8'h48);       // sw   $1,0x48($0)
    prog[2] = enc_j(2);
    push_ret(7, 8'd4);
    push_ret(10, 8'd8);
    push_ret(6, 8'd8);
    push_wr(8'h48, 32'h0000_0055);
    load_and_start(3);
    run_prog(500);

    // Taken beq back onto itself.
    clear_prog();
    prog[0] = enc_j(4);                        // -> 0x10
    prog[4] = enc_i(8'h04, 0, 0, -1);          // beq $0,$0,-1
    push_ret(3, 8'h10);
    push_ret(3, 8'h10);
    push_ret(3, 8'h10);
    load_and_start(0);
    run_prog(500);

    // Not-taken beq, jump to top of memory, pc wrap.
    clear_prog();
    prog[0]  = enc_i(8'h08, 0, 1, 1);          // addi $1,$0,1
    prog[1]  = enc_i(8'h04, 1, 0, 5);          // beq  $1,$0,5
    prog[2]  = enc_j(8'h3F);                   // -> 0xFC
    prog[63] = enc_i(8'h08, 0, 4, 7);          // addi at 0xFC
    push_ret(4, 8'h04);
    push_ret(3, 8'h08);
    push_ret(3, 8'hFC);
    push_ret(4, 8'h00);
    push_ret(4, 8'h04);
    load_and_start(0);
    run_prog(500);

    // Reset during the MEM phase of a store.
    clear_prog();
    prog[0] = enc_i(8'h08, 0, 5, 9);           // addi $5,$0,9
    prog[1] = enc_i(8'h2B, 0, 5, 8'h40);       // sw   $5,0x40($0)
    prog[2] = enc_j(2);
    push_ret(6, 8'd4);
    load_and_start(2);
    begin
      int n = 0;
      while (state_out !== S_MEM && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("reach_mem", {29'h0, state_out}, {29'h0, S_MEM});
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("abort_mem_req", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_pc", {24'h0, pc_out}, 32'h0);
    check("abort_state", {29'h0, state_out}, {29'h0, S_FETCH});
    check("abort_retired", retired, 32'h0);
    check("abort_ret_q", ret_q.size(), 0);
    check("abort_no_write", mem[16], 32'h0);
    rst = 1'b1;
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
